// File: rtl/phase_unwrapper.sv
// Phase unwrapper: turns wrapped CORDIC phase samples into a continuous multi-turn phase,
// with a saturating accumulator, sticky overflow flag and boxcar-decimated average.
module phase_unwrapper #(
  parameter int unsigned PHASE_WIDTH = 24,
  parameter int unsigned OUT_WIDTH   = 32,
  parameter int unsigned LOG2_AVG    = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [PHASE_WIDTH-1:0] phi_i,
  input  logic                   phi_valid_i,
  input  logic                   clear_i,
  output logic [OUT_WIDTH-1:0]   unwrapped_o,
  output logic [OUT_WIDTH-1:0]   avg_o,
  output logic                   avg_valid_o,
  output logic                   overflow_o
);

  localparam int unsigned SumW = OUT_WIDTH + LOG2_AVG;
  localparam int unsigned CntW = LOG2_AVG + 1;
  localparam logic [CntW-1:0] AvgLen = CntW'(2 ** LOG2_AVG);
  localparam logic [OUT_WIDTH-1:0] MaxVal = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MinVal = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [0:0] {StEmpty, StRun} state_e;

  state_e                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] phi_prev_q, phi_prev_d;
  logic [OUT_WIDTH-1:0]   unwrapped_q, unwrapped_d;
  logic [OUT_WIDTH-1:0]   avg_q, avg_d;
  logic                   avg_valid_q, avg_valid_d;
  logic                   overflow_q, overflow_d;
  logic [SumW-1:0]        sum_q, sum_d;
  logic [CntW-1:0]        count_q, count_d;

  logic signed [PHASE_WIDTH-1:0] delta;
  logic signed [OUT_WIDTH:0]     acc;
  logic signed [OUT_WIDTH-1:0]   new_unw;
  logic signed [SumW-1:0]        sum_base, sum_next;
  logic [CntW-1:0]               cnt_base, cnt_next;
  logic                          first;
  logic                          sat_hit;

  always_comb begin
    state_d     = state_q;
    phi_prev_d  = phi_prev_q;
    unwrapped_d = unwrapped_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    overflow_d  = overflow_q;
    sum_d       = sum_q;
    count_d     = count_q;

    // Modular subtraction yields the shortest signed step; -half-scale stays negative.
    delta = phi_i - phi_prev_q;
    acc   = $signed({unwrapped_q[OUT_WIDTH-1], unwrapped_q}) + (OUT_WIDTH + 1)'(delta);
    first = clear_i || (state_q == StEmpty);

    sat_hit = 1'b0;
    if (first) begin
      new_unw = OUT_WIDTH'($signed(phi_i));
    end else if (acc[OUT_WIDTH] != acc[OUT_WIDTH-1]) begin
      sat_hit = 1'b1;
      new_unw = acc[OUT_WIDTH] ? MinVal : MaxVal;
    end else begin
      new_unw = acc[OUT_WIDTH-1:0];
    end

    sum_base = first ? '0 : $signed(sum_q);
    cnt_base = first ? '0 : count_q;
    sum_next = sum_base + SumW'(new_unw);
    cnt_next = cnt_base + CntW'(1);

    if (clear_i) begin
      state_d    = StEmpty;
      sum_d      = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end

    if (phi_valid_i) begin
      state_d     = StRun;
      phi_prev_d  = phi_i;
      unwrapped_d = new_unw;
      if (sat_hit) begin
        overflow_d = 1'b1;
      end
      if (cnt_next == AvgLen) begin
        avg_d       = OUT_WIDTH'(sum_next >>> LOG2_AVG);
        avg_valid_d = 1'b1;
        sum_d       = '0;
        count_d     = '0;
      end else begin
        sum_d   = sum_next;
        count_d = cnt_next;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StEmpty;
      phi_prev_q  <= '0;
      unwrapped_q <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      sum_q       <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      phi_prev_q  <= phi_prev_d;
      unwrapped_q <= unwrapped_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      overflow_q  <= overflow_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
    end
  end

  assign unwrapped_o = unwrapped_q;
  assign avg_o       = avg_q;
  assign avg_valid_o = avg_valid_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_phase_unwrapper.sv
// Self-checking bench for phase_unwrapper: directed scenarios plus random traffic,
// compared every cycle against an arithmetic model of unwrapping, clamping and averaging.
module tb_phase_unwrapper;

  localparam int W  = 24;
  localparam int OW = 26;
  localparam int L  = 2;
  localparam int N  = 4;

  localparam longint Full = longint'(1) << W;
  localparam longint Half = longint'(1) << (W - 1);
  localparam longint OMax = (longint'(1) << (OW - 1)) - 1;
  localparam longint OMin = -(longint'(1) << (OW - 1));

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic [W-1:0]  phi_i = '0;
  logic          phi_valid_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [OW-1:0] unwrapped_o;
  logic [OW-1:0] avg_o;
  logic          avg_valid_o;
  logic          overflow_o;

  phase_unwrapper #(
    .PHASE_WIDTH(W),
    .OUT_WIDTH  (OW),
    .LOG2_AVG   (L)
  ) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .phi_i      (phi_i),
    .phi_valid_i(phi_valid_i),
    .clear_i    (clear_i),
    .unwrapped_o(unwrapped_o),
    .avg_o      (avg_o),
    .avg_valid_o(avg_valid_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  longint m_unw = 0;
  longint m_avg = 0;
  bit     m_av = 1'b0;
  bit     m_ovf = 1'b0;
  bit     m_have = 1'b0;
  longint m_prev = 0;
  longint blk[$];

  function automatic longint floor_div(input longint s, input longint d);
    longint q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int wrapph(input longint x);
    longint m;
    m = ((x % Full) + Full) % Full;
    if (m >= Half) m = m - Full;
    return int'(m);
  endfunction

  function automatic longint sx(input logic [OW-1:0] v);
    return longint'($signed(v));
  endfunction

  initial begin
    longint p, d, t, s;
    forever begin
      @(posedge clk_i or negedge reset_ni);
      if (!reset_ni) begin
        m_unw = 0; m_avg = 0; m_av = 0; m_ovf = 0; m_have = 0; m_prev = 0;
        blk.delete();
      end else begin
        m_av = 1'b0;
        if (clear_i) begin
          m_have = 1'b0;
          m_ovf = 1'b0;
          blk.delete();
        end
        if (phi_valid_i) begin
          p = longint'($signed(phi_i));
          if (!m_have) begin
            m_unw = p;
          end else begin
            d = p - m_prev;
            if (d >= Half) d = d - Full;
            if (d < -Half) d = d + Full;
            t = m_unw + d;
            if (t > OMax) begin t = OMax; m_ovf = 1'b1; end
            if (t < OMin) begin t = OMin; m_ovf = 1'b1; end
            m_unw = t;
          end
          m_prev = p;
          m_have = 1'b1;
          blk.push_back(m_unw);
          if (blk.size() == N) begin
            s = 0;
            foreach (blk[i]) s = s + blk[i];
            m_avg = floor_div(s, N);
            m_av = 1'b1;
            blk.delete();
          end
        end
      end
    end
  end

  task automatic cmp(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk_i);
      cmp("unwrapped", sx(unwrapped_o), m_unw);
      cmp("avg", sx(avg_o), m_avg);
      cmp("avg_valid", longint'(avg_valid_o), longint'(m_av));
      cmp("overflow", longint'(overflow_o), longint'(m_ovf));
    end
  end

  task automatic send(input bit v, input int phi, input bit clr);
    @(negedge clk_i);
    phi_valid_i = v;
    phi_i = phi[W-1:0];
    clear_i = clr;
    @(posedge clk_i);
    #1;
    phi_valid_i = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int ph;
    longint base;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    cmp("rst_unw", sx(unwrapped_o), 0);
    cmp("rst_ovf", longint'(overflow_o), 0);
    cmp("rst_avv", longint'(avg_valid_o), 0);
    @(negedge clk_i);
    reset_ni = 1'b1;

    // Basic tracking
    send(1, 0, 0);     cmp("basic0", sx(unwrapped_o), 0);
    send(1, 1000, 0);  cmp("basic1", sx(unwrapped_o), 1000);
    send(1, -1000, 0); cmp("basic2", sx(unwrapped_o), -1000);
    cmp("basic_ovf", longint'(overflow_o), 0);

    // Positive wrap then a steady +600000 ramp
    send(1, 8388000, 1);  cmp("wrap0", sx(unwrapped_o), 8388000);
    send(1, -8388000, 0); cmp("wrap1", sx(unwrapped_o), 8389216);
    ph = -8388000;
    base = 8389216;
    for (int k = 1; k <= 40; k++) begin
      ph = wrapph(longint'(ph) + 600000);
      send(1, ph, 0);
      cmp("ramp", sx(unwrapped_o), base + longint'(k) * 600000);
    end
    // Further rounds, each re-referenced, covering about ten turns in total
    for (int r = 0; r < 4; r++) begin
      ph = -8388000;
      send(1, ph, 1);
      for (int k = 1; k <= 69; k++) begin
        ph = wrapph(longint'(ph) + 600000);
        send(1, ph, 0);
        cmp("ramp_r", sx(unwrapped_o), -8388000 + longint'(k) * 600000);
      end
    end
    cmp("ramp_ovf", longint'(overflow_o), 0);

    // Averaging
    send(0, 0, 1);
    send(1, 10, 0);
    send(1, 20, 0);
    send(1, 30, 0); cmp("avg_nv", longint'(avg_valid_o), 0);
    send(1, 40, 0); cmp("avg_v1", longint'(avg_valid_o), 1); cmp("avg25", sx(avg_o), 25);
    idle(1);        cmp("avg_pulse", longint'(avg_valid_o), 0);
    send(1, 41, 0); send(1, 42, 0); send(1, 43, 0); send(1, 44, 0);
    cmp("avg42", sx(avg_o), 42);
    send(1, -1, 0); send(1, -2, 0); send(1, -2, 0); send(1, -2, 0);
    cmp("avg_neg", sx(avg_o), -2);

    // Saturation
    ph = 0;
    send(1, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      ph = wrapph(longint'(ph) + 4000000);
      send(1, ph, 0);
    end
    cmp("sat_pre", longint'(overflow_o), 0);
    ph = wrapph(longint'(ph) + 4000000);
    send(1, ph, 0);
    cmp("sat_clamp", sx(unwrapped_o), 33554431);
    cmp("sat_ovf", longint'(overflow_o), 1);
    ph = wrapph(longint'(ph) + 4000000);
    send(1, ph, 0);
    cmp("sat_hold", sx(unwrapped_o), 33554431);
    ph = wrapph(longint'(ph) - 1000000);
    send(1, ph, 0);
    cmp("sat_back", sx(unwrapped_o), 32554431);
    cmp("sat_sticky", longint'(overflow_o), 1);
    send(0, 0, 1);
    cmp("sat_clr", longint'(overflow_o), 0);
    cmp("sat_clr_hold", sx(unwrapped_o), 32554431);

    // Clear colliding with a sample
    send(1, 10000, 1);
    send(1, 30000, 0);
    send(1, 50000, 0);
    cmp("col_pre", sx(unwrapped_o), 50000);
    send(1, 5000, 1);
    cmp("col_unw", sx(unwrapped_o), 5000);
    send(1, 6000, 0); cmp("col_nv1", longint'(avg_valid_o), 0);
    send(1, 7000, 0); cmp("col_nv2", longint'(avg_valid_o), 0);
    send(1, 8000, 0); cmp("col_v", longint'(avg_valid_o), 1);
    cmp("col_avg", sx(avg_o), 6500);

    // Async reset mid-operation
    send(1, 100, 1);
    send(1, 200, 0);
    @(posedge clk_i);
    #3;
    reset_ni = 1'b0;
    #1;
    cmp("ar_unw", sx(unwrapped_o), 0);
    cmp("ar_avg", sx(avg_o), 0);
    cmp("ar_ovf", longint'(overflow_o), 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    send(1, 7777, 0); cmp("ar_first", sx(unwrapped_o), 7777);
    send(1, 7777, 0);
    send(1, 7777, 0); cmp("ar_nv", longint'(avg_valid_o), 0);
    send(1, 7777, 0); cmp("ar_avg2", sx(avg_o), 7777);

    // Random traffic, mixing small steps and arbitrary jumps
    ph = 0;
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 4) ph = wrapph(longint'(ph) + longint'($urandom_range(0, 200000)) - 100000);
      else if (sel < 6) ph = int'($urandom);
      else if (sel < 8) ph = wrapph(longint'(ph) + 8388607 - longint'($urandom_range(0, 1)));
      send(($urandom_range(0, 2) != 0), wrapph(longint'(ph)), ($urandom_range(0, 63) == 0));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
